// File: rtl/uart_mm_csr.sv
// Avalon-MM CSR slave for the UART: TX/RX byte FIFOs, status/level/ctrl registers and
// a level interrupt. All state uses a synchronous active-high reset.
module uart_mm_csr #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BUS_W    = 32,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [2:0]        avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [BUS_W-1:0]  avs_writedata_i,
    output logic [BUS_W-1:0]  avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              irq_o
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_LW = TX_AW + 1;
    localparam int unsigned RX_LW = RX_AW + 1;
    localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);
    localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_AW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TX_LW-1:0]  tx_level_q, tx_level_d;
    logic [RX_LW-1:0]  rx_level_q, rx_level_d;
    logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [BUS_W-1:0]  rdata_q, rdata_d;
    logic              rvalid_q;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic wr_txdata, wr_ctrl, wr_clear, rd_rxdata;
    logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
    logic [5:0]  status;
    logic [31:0] level_word;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata_i;

    assign tx_empty = (tx_level_q == '0);
    assign tx_full  = (tx_level_q == TX_FULL_LVL);
    assign rx_empty = (rx_level_q == '0);
    assign rx_full  = (rx_level_q == RX_FULL_LVL);

    assign wr_txdata = avs_write_i && (avs_address_i == 3'd0);
    assign wr_ctrl   = avs_write_i && (avs_address_i == 3'd3);
    assign wr_clear  = avs_write_i && (avs_address_i == 3'd5);
    assign rd_rxdata = avs_read_i && (avs_address_i == 3'd2);

    assign tx_valid_o = ctrl_q[0] & ~tx_empty;
    assign tx_data_o  = tx_mem_q[tx_rptr_q];

    // Full/empty come from pre-edge state, so a pop never makes room for a same-cycle push.
    assign tx_push  = wr_txdata & ~tx_full;
    assign tx_pop   = tx_valid_o & tx_ready_i;
    assign tx_flush = wr_clear & avs_writedata_i[2];
    assign rx_push  = rx_valid_i & ~rx_full;
    assign rx_pop   = rd_rxdata & ~rx_empty;
    assign rx_flush = wr_clear & avs_writedata_i[3];

    assign status     = {rx_ovf_q, tx_ovf_q, rx_full, ~rx_empty, tx_full, tx_empty};
    assign level_word = {16'(rx_level_q), 16'(tx_level_q)};

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_level_d = tx_level_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + TX_LW'(1);
            2'b01:   tx_level_d = tx_level_q - TX_LW'(1);
            default: tx_level_d = tx_level_q;
        endcase
        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_level_d = '0;
        end
    end

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_level_d = rx_level_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + RX_LW'(1);
            2'b01:   rx_level_d = rx_level_q - RX_LW'(1);
            default: rx_level_d = rx_level_q;
        endcase
        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_level_d = '0;
        end
    end

    // Clear first, then set, so a same-cycle overflow beats the CLEAR.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (wr_clear && avs_writedata_i[0]) tx_ovf_d = 1'b0;
        if (wr_clear && avs_writedata_i[1]) rx_ovf_d = 1'b0;
        if (wr_txdata && tx_full)           tx_ovf_d = 1'b1;
        if (rx_valid_i && rx_full)          rx_ovf_d = 1'b1;
        ctrl_d = wr_ctrl ? avs_writedata_i[2:0] : ctrl_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read_i) begin
            case (avs_address_i)
                3'd1:    rdata_d = BUS_W'(status);
                3'd2:    rdata_d = rx_empty ? '0 : BUS_W'(rx_mem_q[rx_rptr_q]);
                3'd3:    rdata_d = BUS_W'(ctrl_q);
                3'd4:    rdata_d = BUS_W'(level_word);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= avs_read_i;
        end
    end

    // Storage needs no reset; the levels alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= avs_writedata_i[DATA_W-1:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
    end

    assign avs_readdata_o      = rdata_q;
    assign avs_readdatavalid_o = rvalid_q;
    assign irq_o = (ctrl_q[1] & ~rx_empty) | (ctrl_q[2] & tx_empty);

endmodule
